// File: rtl/rotary_quad_emitter.sv
// rotary_quad_emitter
//   Quadrature transmitter. Each accepted command produces one detent on
//   oROT_A/oROT_B using the same Gray-code waveform as the board's rotary
//   encoder, so it can drive Rotation_direction through the top-level ROT mux.
//   Detents are counted in 'pending', so commands can be queued while a detent
//   is still being emitted.
//
//   Rest level (A,B) = 00. One detent visits four phases, one per state:
//     right: 01 -> 11 -> 10 -> 00
//     left : 10 -> 11 -> 01 -> 00
//   Each phase is held for STEP_CYCLES clocks, so one detent lasts
//   4*STEP_CYCLES clocks.
//
// Handshake: a command is accepted on a rising clock edge where
//   cmd_valid && cmd_ready. cmd_ready is combinational and does not depend on
//   cmd_valid. If cmd_valid is high while cmd_ready is low, the request is
//   ignored and is not remembered.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous, active-high
//   cmd_valid  in   request one detent
//   cmd_right  in   direction of the request (1 = right, 0 = left)
//   cmd_ready  out  request can be accepted this cycle
//   flush      in   drop queued detents; the detent in progress completes
//   oROT_A     out  registered quadrature A
//   oROT_B     out  registered quadrature B
//   busy       out  registered, high while the FSM is not IDLE
//   pending    out  registered count of detents accepted but not completed
//   dbg_state  out  current FSM state encoding
module rotary_quad_emitter #(
  parameter int STEP_CYCLES = 5000,
  parameter int CNT_W       = 4,
  parameter int MAX_PENDING = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_right,
  output logic             cmd_ready,
  input  logic             flush,
  output logic             oROT_A,
  output logic             oROT_B,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4
  } state_t;

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  // The timer counts down from STEP_CYCLES-1. A phase ends on the edge where
  // the timer already reads 0, so each phase lasts exactly STEP_CYCLES clocks.
  localparam logic [TW-1:0]    T_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PENDING);

  state_t          state;
  logic [TW-1:0]   timer;
  logic            dir;
  logic            accept;
  logic            expire;
  logic [CNT_W-1:0] pend_next;

  assign dbg_state = state;

  // A reversal has to wait until the queue has drained. The direction is
  // latched only when pending is 0, and that only happens in IDLE.
  assign cmd_ready = !flush && (pending < MAX_P) &&
                     ((pending == '0) || (cmd_right == dir));
  assign accept    = cmd_valid && cmd_ready;
  assign expire    = (state == PH4) && (timer == '0);

  // Flush takes priority. It keeps only the detent in progress, and it
  // keeps nothing if that detent completes on the same edge.
  always_comb begin
    pend_next = pending;
    if (flush) begin
      if (expire || state == IDLE) pend_next = '0;
      else                         pend_next = CNT_W'(1);
    end else begin
      case ({accept, expire})
        2'b10:   pend_next = pending + 1'b1;
        2'b01:   pend_next = pending - 1'b1;
        default: pend_next = pending;
      endcase
    end
  end

  function automatic logic [1:0] ab_of(input state_t s, input logic d);
    case (s)
      PH1:     ab_of = d ? 2'b01 : 2'b10;
      PH2:     ab_of = 2'b11;
      PH3:     ab_of = d ? 2'b10 : 2'b01;
      default: ab_of = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      dir     <= 1'b0;
      oROT_A  <= 1'b0;
      oROT_B  <= 1'b0;
      busy    <= 1'b0;
      pending <= '0;
    end else begin
      pending <= pend_next;
      case (state)
        IDLE: begin
          if (accept) begin
            dir              <= cmd_right;
            timer            <= T_LOAD;
            state            <= PH1;
            {oROT_A, oROT_B} <= ab_of(PH1, cmd_right);
            busy             <= 1'b1;
          end
        end
        PH1, PH2, PH3: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            timer <= T_LOAD;
            if (state == PH1) begin
              state            <= PH2;
              {oROT_A, oROT_B} <= ab_of(PH2, dir);
            end else if (state == PH2) begin
              state            <= PH3;
              {oROT_A, oROT_B} <= ab_of(PH3, dir);
            end else begin
              state            <= PH4;
              {oROT_A, oROT_B} <= ab_of(PH4, dir);
            end
          end
        end
        PH4: begin
          if (!expire) begin
            timer <= timer - 1'b1;
          end else if (pend_next != '0) begin
            // Back-to-back detent. The direction is unchanged because
            // cmd_ready only accepts commands in the latched direction.
            timer            <= T_LOAD;
            state            <= PH1;
            {oROT_A, oROT_B} <= ab_of(PH1, dir);
          end else begin
            state            <= IDLE;
            {oROT_A, oROT_B} <= 2'b00;
            busy             <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          {oROT_A, oROT_B} <= 2'b00;
          busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_quad_emitter.sv
// Bench for rotary_quad_emitter with STEP_CYCLES=4, CNT_W=4, MAX_PENDING=3.
// Each vector gives the inputs driven for one clock cycle. It also gives the
// cmd_ready expected before the rising edge, and the registered outputs
// expected after that edge.
module tb_rotary_quad_emitter;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_right;
  logic       cmd_ready;
  logic       flush;
  logic       rot_a;
  logic       rot_b;
  logic       busy;
  logic [3:0] pending;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  rotary_quad_emitter #(
    .STEP_CYCLES(4),
    .CNT_W      (4),
    .MAX_PENDING(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_right(cmd_right),
    .cmd_ready(cmd_ready),
    .flush    (flush),
    .oROT_A   (rot_a),
    .oROT_B   (rot_b),
    .busy     (busy),
    .pending  (pending),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic       r;
    logic       f;
    logic       rdy;
    logic [1:0] ab;
    logic       bsy;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  logic [1:0] pat_r[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] pat_l[4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  // scoreboard
  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic r, input logic f, input logic rdy,
                     input logic [1:0] ab, input logic bsy, input logic [3:0] pend);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.rdy = rdy; x.ab = ab; x.bsy = bsy; x.pend = pend;
    vecs.push_back(x);
  endtask

  // driver: called at posedge+1
  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      cmd_valid = vecs[i].v;
      cmd_right = vecs[i].r;
      flush     = vecs[i].f;
      #1;
      check({name, ".rdy"}, i, {7'd0, cmd_ready}, {7'd0, vecs[i].rdy});
      @(posedge clock);
      #1;
      check({name, ".ab"},   i, {6'd0, rot_a, rot_b}, {6'd0, vecs[i].ab});
      check({name, ".busy"}, i, {7'd0, busy}, {7'd0, vecs[i].bsy});
      check({name, ".pend"}, i, {4'd0, pending}, {4'd0, vecs[i].pend});
    end
    cmd_valid = 1'b0;
    flush     = 1'b0;
    vecs.delete();
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".ab"},   0, {6'd0, rot_a, rot_b}, 8'd0);
    check({name, ".busy"}, 0, {7'd0, busy}, 8'd0);
    check({name, ".pend"}, 0, {4'd0, pending}, 8'd0);
    check({name, ".rdy"},  0, {7'd0, cmd_ready}, 8'd1);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_right = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    #1;
    check_reset_state("reset0");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // One right detent: 01,11,10,00 for 4 clocks each, idle at clock 16.
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    for (int k = 1; k < 16; k++) add(0, 1, 0, 1, pat_r[k/4], 1, 4'd1);
    add(0, 1, 0, 1, 2'b00, 0, 4'd0);
    run_table("right1");

    // Three left detents on consecutive clocks, fourth refused, 48 clocks.
    for (int k = 0; k <= 48; k++) begin
      int prev, pend;
      pend = (k < 3) ? k + 1 : (k < 16) ? 3 : (k < 32) ? 2 : (k < 48) ? 1 : 0;
      prev = (k == 0) ? 0 : (k < 4) ? k : (k < 17) ? 3 : (k < 33) ? 2 : (k < 49) ? 1 : 0;
      add((k <= 3), 0, 0, (prev < 3), (k < 48) ? pat_l[(k % 16) / 4] : 2'b00,
          (k < 48), 4'(pend));
    end
    run_table("left3");

    // Two right detents queued, then a left request stalls until the queue drains.
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    add(1, 1, 0, 1, 2'b01, 1, 4'd2);
    for (int k = 2; k <= 32; k++)
      add(1, 0, 0, 0, (k < 32) ? pat_r[(k % 16) / 4] : 2'b00, (k < 32),
          (k < 16) ? 4'd2 : (k < 32) ? 4'd1 : 4'd0);
    add(1, 0, 0, 1, 2'b10, 1, 4'd1);
    for (int k = 34; k <= 48; k++) add(0, 0, 0, 1, pat_l[(k - 33) / 4], 1, 4'd1);
    add(0, 0, 0, 1, 2'b00, 0, 4'd0);
    run_table("reverse");

    // An accept on the PH4 expiry edge keeps pending at 1 and restarts at PH1.
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    for (int k = 1; k < 16; k++) add(0, 1, 0, 1, pat_r[k/4], 1, 4'd1);
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    for (int k = 17; k < 32; k++) add(0, 1, 0, 1, pat_r[(k - 16) / 4], 1, 4'd1);
    add(0, 1, 0, 1, 2'b00, 0, 4'd0);
    run_table("expiry_acc");

    // Flush during PH2 with pending=3 leaves the current detent to finish.
    for (int k = 0; k < 3; k++) add(1, 1, 0, 1, 2'b01, 1, 4'(k + 1));
    add(1, 1, 0, 0, 2'b01, 1, 4'd3);
    add(0, 1, 0, 0, 2'b11, 1, 4'd3);
    add(0, 1, 1, 0, 2'b11, 1, 4'd1);
    for (int k = 6; k < 16; k++) add(0, 1, 0, 1, pat_r[k/4], 1, 4'd1);
    add(0, 1, 0, 1, 2'b00, 0, 4'd0);
    run_table("flush_ph2");

    // Flush on the completion edge with a detent queued goes straight to IDLE.
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    add(1, 1, 0, 1, 2'b01, 1, 4'd2);
    for (int k = 2; k < 16; k++) add(0, 1, 0, 1, pat_r[k/4], 1, 4'd2);
    add(0, 1, 1, 0, 2'b00, 0, 4'd0);
    add(0, 1, 0, 1, 2'b00, 0, 4'd0);
    run_table("flush_end");

    // Reset asserted mid-cycle during PH3: outputs clear without a clock edge.
    add(1, 1, 0, 1, 2'b01, 1, 4'd1);
    for (int k = 1; k < 10; k++) add(0, 1, 0, 1, pat_r[k/4], 1, 4'd1);
    run_table("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("rst_ph3");
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_state("rst_hold");

    // After reset, a fresh left detent starts from IDLE.
    add(1, 0, 0, 1, 2'b10, 1, 4'd1);
    for (int k = 1; k < 16; k++) add(0, 0, 0, 1, pat_l[k/4], 1, 4'd1);
    add(0, 0, 0, 1, 2'b00, 0, 4'd0);
    run_table("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
